// File: rtl/lfsr_pkg.sv
// Shared LFSR types and helpers for the pattern checker and generators.
//   chk_state_t : checker synchronisation state
//   lfsr_fb     : feedback bit = XOR of the tapped state bits
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W = 32;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Callers zero-extend state and taps to LFSR_MAX_W.
  function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] state,
                                   input logic [LFSR_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR step: feedback/expected bit and next shift-register value.
//   state    : current register (MSB oldest)
//   shift_in : bit shifted in when use_fb=0
//   use_fb   : 1 = free-run (shift in feedback), 0 = shift in shift_in
//   fb_c     : feedback bit, i.e. the next expected stream bit
//   next_c   : next register value
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned    N    = 2,
  parameter logic [N-1:0]   TAPS = 2'b11
) (
  input  logic [N-1:0] state,
  input  logic         shift_in,
  input  logic         use_fb,
  output logic         fb_c,
  output logic [N-1:0] next_c
);

  always_comb begin
    fb_c   = lfsr_fb(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS));
    next_c = {state[N-2:0], (use_fb ? fb_c : shift_in)};
  end

endmodule

// File: rtl/lfsr_checker.sv
// Serial LFSR stream checker: self-synchronises to the incoming sequence,
// then free-runs a local copy and flags each mismatching bit.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_valid  : bit_in sampled on this edge; otherwise all state holds
//   bit_in    : serial data under test
//   clr_count : synchronous clear of err_count
//   locked    : checker synchronised (registered)
//   err       : one-cycle pulse, last sampled bit mismatched while locked
//   err_count : saturating count of mismatches seen while locked
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned  N          = 2,
  parameter logic [N-1:0] TAPS       = 2'b11,
  parameter int unsigned  LOCK_COUNT = 4,
  parameter int unsigned  LOSS_COUNT = 4,
  parameter int unsigned  CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             bit_in,
  input  logic             clr_count,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FILL_W  = $clog2(N + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);

  chk_state_t         state_q, state_d;
  logic [N-1:0]       hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic               exp_c;
  logic [N-1:0]       hist_next_c;
  logic               count_hit_c;

  // Once locked the history free-runs on its own feedback, so a single
  // corrupted input bit cannot poison subsequent expectations.
  lfsr_step #(.N(N), .TAPS(TAPS)) u_step (
    .state    (hist_q),
    .shift_in (bit_in),
    .use_fb   (state_q == LOCKED),
    .fb_c     (exp_c),
    .next_c   (hist_next_c)
  );

  // Next-state, counters and outputs.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    count_hit_c = 1'b0;

    if (in_valid) begin
      hist_d = hist_next_c;
      unique case (state_q)
        SEARCH: begin
          if (fill_q == FILL_W'(N - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          // All-zero history is the LFSR lock-up state; never count it.
          if ((bit_in == exp_c) && (hist_q != '0)) begin
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (bit_in != exp_c) begin
            err_d       = 1'b1;
            count_hit_c = 1'b1;
            if (miss_q == MISS_W'(LOSS_COUNT - 1)) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              fill_d   = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d  = SEARCH;
          fill_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end

    // A mismatch coincident with a clear is still recorded.
    if (clr_count) begin
      err_count_d = count_hit_c ? CNT_W'(1) : '0;
    end else if (count_hit_c && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (N=2, TAPS=11, lock/loss counts 4).
// Reference stream is 1,1,0 repeating; p tracks the stream phase over valid bits.
module tb_lfsr_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        bit_in;
  logic        clr_count;
  logic        locked;
  logic        err;
  logic [15:0] err_count;

  int n_pass;
  int n_total;
  int p;

  lfsr_checker #(
    .N(2), .TAPS(2'b11), .LOCK_COUNT(4), .LOSS_COUNT(4), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .bit_in    (bit_in),
    .clr_count (clr_count),
    .locked    (locked),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pat(input int i);
    return (i % 3) != 2;
  endfunction

  // Drive at negedge, let one posedge pass, return at the following negedge.
  task automatic send(input logic v, input logic b, input logic clr);
    in_valid  = v;
    bit_in    = b;
    clr_count = clr;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    clr_count = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; bit_in = 1'b0; clr_count = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", err_count); else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b1, 1'b0);
      n_total++; if (locked !== 1'b0 || err !== 1'b0)
        $display("FAIL idle_%0d: locked=%b err=%b want 0/0", i, locked, err); else n_pass++;
    end
  endtask

  task automatic test_lock();
    p = 0;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, pat(p), 1'b0); p++;
      n_total++; if (locked !== (i == 5))
        $display("FAIL lock_bit%0d: locked=%b want %b", i + 1, locked, (i == 5)); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL lock_err%0d: got %b want 0", i + 1, err); else n_pass++;
    end
    n_total++; if (err_count !== 16'd0) $display("FAIL lock_count: got %0d want 0", err_count); else n_pass++;
  endtask

  task automatic test_single_err();
    // p=6 -> expected bit is 1; send 0 instead
    send(1'b1, ~pat(p), 1'b0); p++;
    n_total++; if (err !== 1'b1) $display("FAIL single_err: got %b want 1", err); else n_pass++;
    n_total++; if (err_count !== 16'd1) $display("FAIL single_count: got %0d want 1", err_count); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL single_locked: got %b want 1", locked); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, pat(p), 1'b0); p++;
      n_total++; if (err !== 1'b0 || locked !== 1'b1)
        $display("FAIL single_after%0d: err=%b locked=%b want 0/1", i, err, locked); else n_pass++;
    end
    n_total++; if (err_count !== 16'd1) $display("FAIL single_count_hold: got %0d want 1", err_count); else n_pass++;
  endtask

  task automatic test_loss();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, ~pat(p), 1'b0); p++;
      n_total++; if (err !== 1'b1) $display("FAIL loss_err%0d: got %b want 1", i, err); else n_pass++;
      n_total++; if (locked !== (i < 3))
        $display("FAIL loss_locked%0d: got %b want %b", i, locked, (i < 3)); else n_pass++;
    end
    n_total++; if (err_count !== 16'd5) $display("FAIL loss_count: got %0d want 5", err_count); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, pat(p), 1'b0); p++;
      n_total++; if (locked !== (i == 5) || err !== 1'b0)
        $display("FAIL relock_bit%0d: locked=%b err=%b want %b/0", i + 1, locked, err, (i == 5)); else n_pass++;
    end
    n_total++; if (err_count !== 16'd5) $display("FAIL relock_count: got %0d want 5", err_count); else n_pass++;
  endtask

  task automatic test_zeros();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b0, 1'b0);
      n_total++; if (locked !== 1'b0 || err !== 1'b0)
        $display("FAIL zeros_%0d: locked=%b err=%b want 0/0", i, locked, err); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int gaps [6];
    gaps = '{1, 0, 2, 0, 3, 1};
    do_reset();
    p = 0;
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        send(1'b0, ~pat(p), 1'b0);
        n_total++; if (locked !== 1'b0 || err !== 1'b0)
          $display("FAIL gap_%0d_%0d: locked=%b err=%b want 0/0", i, g, locked, err); else n_pass++;
      end
      send(1'b1, pat(p), 1'b0); p++;
      n_total++; if (locked !== (i == 5))
        $display("FAIL gap_lock%0d: locked=%b want %b", i + 1, locked, (i == 5)); else n_pass++;
    end
    // invalid garbage while locked must be ignored
    for (int g = 0; g < 2; g++) begin
      send(1'b0, ~pat(p), 1'b0);
      n_total++; if (locked !== 1'b1 || err !== 1'b0 || err_count !== 16'd0)
        $display("FAIL hold_%0d: locked=%b err=%b cnt=%0d want 1/0/0", g, locked, err, err_count); else n_pass++;
    end
    send(1'b1, ~pat(p), 1'b0); p++;
    send(1'b1, pat(p), 1'b0); p++;
    n_total++; if (err_count !== 16'd1) $display("FAIL pre_clr: got %0d want 1", err_count); else n_pass++;
    send(1'b1, pat(p), 1'b1); p++;
    n_total++; if (err_count !== 16'd0) $display("FAIL clr_only: got %0d want 0", err_count); else n_pass++;
    send(1'b1, ~pat(p), 1'b0); p++;
    send(1'b1, pat(p), 1'b0); p++;
    n_total++; if (err_count !== 16'd1) $display("FAIL post_clr: got %0d want 1", err_count); else n_pass++;
    send(1'b1, ~pat(p), 1'b1); p++;
    n_total++; if (err_count !== 16'd1 || err !== 1'b1)
      $display("FAIL clr_hit: cnt=%0d err=%b want 1/1", err_count, err); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL clr_locked: got %b want 1", locked); else n_pass++;
    // asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    n_total++; if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0)
      $display("FAIL async_rst: locked=%b err=%b cnt=%0d want 0/0/0", locked, err, err_count); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    p       = 0;
    test_reset();
    test_lock();
    test_single_err();
    test_loss();
    test_zeros();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
